// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_sched_pkg
// Purpose  : Shared constants and types for the ALU scheduler slice.
//            FLAG_W       - width of the ALU flag vector
//            FLAG_*       - bit positions inside {t,gt,ge,eq,le,lt,ne,zero}
//            ID_REQ0/1    - requester tags carried with each operation
//            x_ctl_t      - non-operand fields held in the issue stage
// Revision : 1.0 - initial release
// ============================================================================
package alu_sched_pkg;

  localparam int FLAG_W = 8;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NE   = 1;
  localparam int FLAG_LT   = 2;
  localparam int FLAG_LE   = 3;
  localparam int FLAG_EQ   = 4;
  localparam int FLAG_GE   = 5;
  localparam int FLAG_GT   = 6;
  localparam int FLAG_T    = 7;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  // Issue-stage control fields (operands are kept separately because their
  // width is a module parameter).
  typedef struct packed {
    logic       id;
    logic [1:0] ctrl;
    logic       sgn;
  } x_ctl_t;

endpackage : alu_sched_pkg
`default_nettype wire

// File: rtl/alu_sched_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way arbiter for the ALU scheduler.
//            Default build: round-robin, the requester that did not win the
//            last grant wins the next contention.
//            With ALU_SCHED_FIXED_PRIO_EN defined: req[0] always wins and no
//            history state exists.
// Ports    : clk      in  clock, rising edge
//            reset_n  in  synchronous active-low reset
//            en       in  arbitration allowed this cycle (issue slot free)
//            req[1:0] in  request valids
//            ready[1:0] out per-port ready; never depends on the same port's
//                       valid, only on the other port's valid and history
//            grant[1:0] out one-hot accepted request (req & ready)
// Config   : ALU_SCHED_FIXED_PRIO_EN
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] ready,
  output logic [1:0] grant
);

`ifdef ALU_SCHED_FIXED_PRIO_EN

  // req0 is always ready when a slot is free; req1 only when req0 is idle.
  always_comb begin
    ready    = 2'b00;
    ready[0] = en;
    ready[1] = en && !req[0];
    grant    = req & ready;
  end

`else

  logic last_grant_q;
  logic last_grant_d;

  // Winner of a contention is the port that did not win last time. Each
  // port's ready looks only at the other port's valid, so there is no
  // valid->ready loop on the same port.
  always_comb begin
    ready    = 2'b00;
    ready[0] = en && (!req[1] || last_grant_q);
    ready[1] = en && (!req[0] || !last_grant_q);
    grant    = req & ready;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (|grant) begin
      last_grant_d = grant[1];
    end
  end

  // Reset to 1 so req0 wins the first contention after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

`endif

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_scheduler
// Purpose  : Shares one external combinational ALU between two requesters.
//            Granted operands are registered into an issue stage (X) that
//            drives the ALU; the ALU outputs are captured into a response
//            stage (R) tagged with the issuing requester's ID.
// Ports    : clk, reset_n              clock / sync active-low reset
//            reqN_valid/ready          request handshake, N = 0,1
//            reqN_a, reqN_b            operands (WIDTH)
//            reqN_ctrl, reqN_signed    ALU op select / signed compare
//            alu_a, alu_b, alu_ctrl,   to ALU, driven only from X registers
//            alu_signed_comp
//            alu_s, alu_overflow,      from ALU
//            alu_flags
//            rsp_valid/ready           response handshake
//            rsp_id, rsp_s,            registered response
//            rsp_overflow, rsp_flags
// Config   : ALU_SCHED_FIXED_PRIO_EN (fixed priority to req0; see
//            rr_arbiter2)
// Revision : 1.0 - initial release
// ============================================================================
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [1:0]        req0_ctrl,
  input  logic              req0_signed,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [1:0]        req1_ctrl,
  input  logic              req1_signed,

  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [1:0]        alu_ctrl,
  output logic              alu_signed_comp,
  input  logic [WIDTH-1:0]  alu_s,
  input  logic              alu_overflow,
  input  logic [FLAG_W-1:0] alu_flags,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_s,
  output logic              rsp_overflow,
  output logic [FLAG_W-1:0] rsp_flags
);

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  logic              x_valid_q,   x_valid_d;
  logic [WIDTH-1:0]  x_a_q,       x_a_d;
  logic [WIDTH-1:0]  x_b_q,       x_b_d;
  x_ctl_t            x_ctl_q,     x_ctl_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0]  rsp_s_q,     rsp_s_d;
  logic              rsp_ovf_q,   rsp_ovf_d;
  logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;

  // --------------------------------------------------------------------------
  // Pipeline advance
  // --------------------------------------------------------------------------
  logic       r_free;
  logic       x_adv;
  logic       x_free;
  logic       arb_en;
  logic [1:0] arb_ready;
  logic [1:0] arb_grant;

  always_comb begin
    r_free = !rsp_valid_q || rsp_ready;
    x_adv  = x_valid_q && r_free;
    x_free = !x_valid_q || x_adv;
    // Gating with reset_n keeps both readies low during the reset cycle so
    // nothing is considered accepted while state is being cleared.
    arb_en = x_free && reset_n;
  end

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en),
    .req     ({req1_valid, req0_valid}),
    .ready   (arb_ready),
    .grant   (arb_grant)
  );

  assign req0_ready = arb_ready[0];
  assign req1_ready = arb_ready[1];

  // --------------------------------------------------------------------------
  // Issue stage (X): load on grant, otherwise hold so the ALU keeps seeing
  // the last operands even after the stage empties.
  // --------------------------------------------------------------------------
  always_comb begin
    x_a_d   = x_a_q;
    x_b_d   = x_b_q;
    x_ctl_d = x_ctl_q;
    if (arb_grant[0]) begin
      x_a_d        = req0_a;
      x_b_d        = req0_b;
      x_ctl_d.id   = ID_REQ0;
      x_ctl_d.ctrl = req0_ctrl;
      x_ctl_d.sgn  = req0_signed;
    end else if (arb_grant[1]) begin
      x_a_d        = req1_a;
      x_b_d        = req1_b;
      x_ctl_d.id   = ID_REQ1;
      x_ctl_d.ctrl = req1_ctrl;
      x_ctl_d.sgn  = req1_signed;
    end
    x_valid_d = (|arb_grant) || (x_valid_q && !x_adv);
  end

  // --------------------------------------------------------------------------
  // Response stage (R): capture ALU outputs when X advances. A drain and a
  // new capture in the same cycle simply overwrite, keeping rsp_valid high.
  // --------------------------------------------------------------------------
  always_comb begin
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_flags_d = rsp_flags_q;
    if (x_adv) begin
      rsp_id_d    = x_ctl_q.id;
      rsp_s_d     = alu_s;
      rsp_ovf_d   = alu_overflow;
      rsp_flags_d = alu_flags;
    end
    rsp_valid_d = x_adv || (rsp_valid_q && !rsp_ready);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_valid_q   <= 1'b0;
      x_a_q       <= '0;
      x_b_q       <= '0;
      x_ctl_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_s_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_flags_q <= '0;
    end else begin
      x_valid_q   <= x_valid_d;
      x_a_q       <= x_a_d;
      x_b_q       <= x_b_d;
      x_ctl_q     <= x_ctl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign alu_a           = x_a_q;
  assign alu_b           = x_b_q;
  assign alu_ctrl        = x_ctl_q.ctrl;
  assign alu_signed_comp = x_ctl_q.sgn;

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_s        = rsp_s_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_flags    = rsp_flags_q;

endmodule : alu_scheduler
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_scheduler
// Purpose  : Directed self-checking bench for alu_scheduler. A small ALU
//            model (ctrl 0=add 1=sub 2=and 3=or) closes the loop.
// Config   : ALU_SCHED_FIXED_PRIO_EN selects fixed-priority expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_scheduler;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [1:0]    req0_ctrl, req1_ctrl;
  logic          req0_signed, req1_signed;
  logic [W-1:0]  alu_a, alu_b, alu_s;
  logic [1:0]    alu_ctrl;
  logic          alu_signed_comp, alu_overflow;
  logic [7:0]    alu_flags;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_overflow;
  logic [W-1:0]  rsp_s;
  logic [7:0]    rsp_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_scheduler #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_a          (req0_a),
    .req0_b          (req0_b),
    .req0_ctrl       (req0_ctrl),
    .req0_signed     (req0_signed),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_a          (req1_a),
    .req1_b          (req1_b),
    .req1_ctrl       (req1_ctrl),
    .req1_signed     (req1_signed),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_ctrl        (alu_ctrl),
    .alu_signed_comp (alu_signed_comp),
    .alu_s           (alu_s),
    .alu_overflow    (alu_overflow),
    .alu_flags       (alu_flags),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_s           (rsp_s),
    .rsp_overflow    (rsp_overflow),
    .rsp_flags       (rsp_flags)
  );

  // Reference ALU
  always_comb begin
    logic lt, eq;
    alu_s        = '0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      2'd0: begin
        alu_s        = alu_a + alu_b;
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_s[W-1] != alu_a[W-1]);
      end
      2'd1: begin
        alu_s        = alu_a - alu_b;
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_s[W-1] != alu_a[W-1]);
      end
      2'd2: alu_s = alu_a & alu_b;
      default: alu_s = alu_a | alu_b;
    endcase
    lt = alu_signed_comp ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b);
    eq = (alu_a == alu_b);
    alu_flags = {1'b1, !lt && !eq, !lt, eq, lt || eq, lt, !eq, alu_s == '0};
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_s  [4];
  logic         exp_id [4];

  initial begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
    exp_s  = '{32'd11, 32'd12, 32'd13, 32'd14};
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_s  = '{32'd11, 32'd23, 32'd13, 32'd25};
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 2'd0; req0_signed = 1'b0;
    req1_valid = 1'b1; req1_a = '0;    req1_b = '0;    req1_ctrl = 2'd0; req1_signed = 1'b0;
    rsp_ready = 1'b1;

    // Reset
    #1;
    chk("reset_ready0", {31'd0, req0_ready}, 32'd0);
    chk("reset_ready1", {31'd0, req1_ready}, 32'd0);
    tick(); tick();
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_s", rsp_s, 32'd0);
    chk("reset_rsp_flags", {24'd0, rsp_flags}, 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_ctrl", {30'd0, alu_ctrl}, 32'd0);

    // Single request: 5 + 3
    reset_n = 1'b1; req1_valid = 1'b0;
    #1;
    chk("single_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("single_alu_a", alu_a, 32'd5);
    chk("single_alu_b", alu_b, 32'd3);
    chk("single_rsp_valid_early", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("single_rsp_s", rsp_s, 32'd8);
    chk("single_rsp_ovf", {31'd0, rsp_overflow}, 32'd0);
    chk("single_rsp_flags", {24'd0, rsp_flags}, 32'hE2);
    tick();
    chk("single_drain", {31'd0, rsp_valid}, 32'd0);

    // Overflow from req1
    req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_ctrl = 2'd0;
    tick();
    req1_valid = 1'b0;
    tick();
    chk("ovf_rsp_s", rsp_s, 32'h8000_0000);
    chk("ovf_rsp_ovf", {31'd0, rsp_overflow}, 32'd1);
    chk("ovf_rsp_id", {31'd0, rsp_id}, 32'd1);
    tick();

    // Contention for 4 cycles
    req0_ctrl = 2'd0; req1_ctrl = 2'd0; req0_b = 32'd1; req1_b = 32'd2;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 32'd10 + W'(i); req1_a = 32'd20 + W'(i);
      #1;
      chk($sformatf("cont_ready0_%0d", i), {31'd0, req0_ready}, {31'd0, !exp_id[i]});
      chk($sformatf("cont_ready1_%0d", i), {31'd0, req1_ready}, {31'd0, exp_id[i]});
      tick();
      if (i > 0) begin
        chk($sformatf("cont_rsp_id_%0d", i-1), {31'd0, rsp_id}, {31'd0, exp_id[i-1]});
        chk($sformatf("cont_rsp_s_%0d", i-1), rsp_s, exp_s[i-1]);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("cont_rsp_id_3", {31'd0, rsp_id}, {31'd0, exp_id[3]});
    chk("cont_rsp_s_3", rsp_s, exp_s[3]);
    tick();
    chk("cont_drain", {31'd0, rsp_valid}, 32'd0);

    // Back-pressure: A = 100-50 (req0), B = 7+8 (req1), C = 1&1 (req0)
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd50; req0_ctrl = 2'd1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd8; req1_ctrl = 2'd0;
    #1;
    chk("bp_ready1_b", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready0_%0d", i), {31'd0, req0_ready}, 32'd0);
      chk($sformatf("bp_ready1_%0d", i), {31'd0, req1_ready}, 32'd0);
      chk($sformatf("bp_rsp_s_%0d", i), rsp_s, 32'd50);
      chk($sformatf("bp_alu_a_%0d", i), alu_a, 32'd7);
      chk($sformatf("bp_alu_b_%0d", i), alu_b, 32'd8);
      tick();
    end
    chk("bp_rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
    chk("bp_rsp_id_a", {31'd0, rsp_id}, 32'd0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("bp_rsp_s_b", rsp_s, 32'd15);
    chk("bp_rsp_id_b", {31'd0, rsp_id}, 32'd1);
    tick();
    chk("bp_rsp_s_c", rsp_s, 32'd1);
    chk("bp_rsp_id_c", {31'd0, rsp_id}, 32'd0);
    tick();
    chk("bp_drain", {31'd0, rsp_valid}, 32'd0);

    // Signed then unsigned compare, back to back: -1 vs 1 / 0xFFFFFFFF vs 1
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_ctrl = 2'd1; req0_signed = 1'b1;
    tick();
    req0_signed = 1'b0;
    tick();
    req0_valid = 1'b0;
    chk("cmp_signed_lt", {31'd0, rsp_flags[2]}, 32'd1);
    chk("cmp_signed_flags", {24'd0, rsp_flags}, 32'h8E);
    tick();
    chk("cmp_unsigned_gt", {31'd0, rsp_flags[6]}, 32'd1);
    chk("cmp_unsigned_flags", {24'd0, rsp_flags}, 32'hE2);
    tick();

    // Reset mid-operation with X and R full (req1 then req0 issued)
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = 2'd0;
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = 2'd0;
    tick();
    req0_valid = 1'b0;
    chk("rst_mid_r_full", {31'd0, rsp_valid}, 32'd1);
    chk("rst_mid_x_full", alu_a, 32'd9);
    reset_n = 1'b0;
    tick();
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_alu_a", alu_a, 32'd0);
    chk("rst_mid_rsp_s", rsp_s, 32'd0);
    reset_n = 1'b1; rsp_ready = 1'b1;
    tick(); tick();
    chk("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd30; req0_b = 32'd1; req1_a = 32'd40; req1_b = 32'd1;
    #1;
    chk("rst_mid_ready0", {31'd0, req0_ready}, 32'd1);
    chk("rst_mid_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("rst_mid_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_mid_rsp_s2", rsp_s, 32'd31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_scheduler
`default_nettype wire
